// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback grant encoding.
package regfile_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int NUM_REGS   = 32;

   typedef enum logic [1:0] {
      GNT_NONE = 2'b00,
      GNT_A    = 2'b01,
      GNT_B    = 2'b10
   } grant_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: two valid/ready sources in, one register-file write port out.
interface regfile_wb_arbiter_if
   import regfile_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
);
   logic              a_valid;
   logic              a_ready;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_data;

   logic              b_valid;
   logic              b_ready;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_data;

   logic              reg_write;
   logic [ADDR_W-1:0] write_reg;
   logic [DATA_W-1:0] write_data;
   logic              busy;

   modport slave (
      input  a_valid, a_addr, a_data,
      input  b_valid, b_addr, b_data,
      output a_ready, b_ready,
      output reg_write, write_reg, write_data, busy
   );

   modport master (
      output a_valid, a_addr, a_data,
      output b_valid, b_addr, b_data,
      input  a_ready, b_ready,
      input  reg_write, write_reg, write_data, busy
   );
endinterface

// File: rtl/wb_fifo.sv
// Small in-order FIFO holding pending register writes for one source.
// Callers only push when !full and only pop when !empty.
module wb_fifo #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0] push_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;

   // NOTE: state registers use <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr] <= push_addr;
         data_mem[wr_ptr] <= push_data;
      end
   end

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign head_addr = addr_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the load-return (A) and ALU (B) writeback streams onto the
// register file's single write port, with starvation protection for B.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int DATA_W       = REG_DATA_W,
   parameter int ADDR_W       = REG_ADDR_W,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 3,
   parameter bit DROP_ZERO    = 1'b1
) (
   input logic                 clk,
   input logic                 reset,
   regfile_wb_arbiter_if.slave bus
);
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
      $error("FIFO_DEPTH must be a power of two >= 2");
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15)
      $error("STARVE_LIMIT must be in 1..15");
   if ((1 << ADDR_W) < NUM_REGS)
      $error("ADDR_W too narrow for the register file");

   logic              a_full, a_empty, a_push, a_pop;
   logic              b_full, b_empty, b_push, b_pop;
   logic [ADDR_W-1:0] a_head_addr, b_head_addr, issue_addr;
   logic [DATA_W-1:0] a_head_data, b_head_data, issue_data;
   grant_e            grant;
   logic [3:0]        starve_cnt;
   logic              reg_write_q;
   logic [ADDR_W-1:0] write_reg_q;
   logic [DATA_W-1:0] write_data_q;

   // Ready comes from pre-edge occupancy: a pop never frees a slot the same edge.
   assign bus.a_ready = !a_full;
   assign bus.b_ready = !b_full;
   assign a_push      = bus.a_valid && !a_full;
   assign b_push      = bus.b_valid && !b_full;

   wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
      .clk       (clk),
      .reset     (reset),
      .push      (a_push),
      .pop       (a_pop),
      .push_addr (bus.a_addr),
      .push_data (bus.a_data),
      .full      (a_full),
      .empty     (a_empty),
      .head_addr (a_head_addr),
      .head_data (a_head_data)
   );

   wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
      .clk       (clk),
      .reset     (reset),
      .push      (b_push),
      .pop       (b_pop),
      .push_addr (bus.b_addr),
      .push_data (bus.b_data),
      .full      (b_full),
      .empty     (b_empty),
      .head_addr (b_head_addr),
      .head_data (b_head_data)
   );

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      grant      = GNT_NONE;
      issue_addr = a_head_addr;
      issue_data = a_head_data;
      if (!a_empty && !b_empty)
         grant = (starve_cnt >= 4'(STARVE_LIMIT)) ? GNT_B : GNT_A;
      else if (!a_empty)
         grant = GNT_A;
      else if (!b_empty)
         grant = GNT_B;
      if (grant == GNT_B) begin
         issue_addr = b_head_addr;
         issue_data = b_head_data;
      end
   end

   assign a_pop = (grant == GNT_A);
   assign b_pop = (grant == GNT_B);

   // Counts consecutive edges where B waited while A won; saturates at 15.
   always_ff @(posedge clk) begin
      if (reset)
         starve_cnt <= '0;
      else if (!b_empty && grant == GNT_A)
         starve_cnt <= (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
      else
         starve_cnt <= '0;
   end

   // A dropped register-0 write still uses its slot and updates write_reg/data.
   always_ff @(posedge clk) begin
      if (reset) begin
         reg_write_q  <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         reg_write_q <= (grant != GNT_NONE) && !(DROP_ZERO && issue_addr == '0);
         if (grant != GNT_NONE) begin
            write_reg_q  <= issue_addr;
            write_data_q <= issue_data;
         end
      end
   end

   assign bus.reg_write  = reg_write_q;
   assign bus.write_reg  = write_reg_q;
   assign bus.write_data = write_data_q;
   assign bus.busy       = !a_empty || !b_empty || reg_write_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: stimulus queues expected register writes, a negedge monitor
// pops and compares them whenever reg_write is high; cycle histories back direct checks.
module tb_regfile_wb_arbiter;
   import regfile_pkg::*;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   wr_t  exp_q[$];
   wr_t  a_items[$];
   wr_t  b_items[$];

   logic        rw_h   [64];
   logic [4:0]  wr_h   [64];
   logic [31:0] wd_h   [64];
   logic        ar_h   [64];
   logic        br_h   [64];
   logic        busy_h [64];

   always #5 clk = ~clk;

   regfile_wb_arbiter_if bus ();

   regfile_wb_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic wr_t mk(input logic [4:0] addr, input logic [31:0] data);
      wr_t w;
      w.addr = addr;
      w.data = data;
      return w;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every issued write must match the head of the expected queue.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (bus.reg_write === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("wb_addr", 32'(bus.write_reg), 32'(e.addr));
               check("wb_data", bus.write_data, e.data);
            end
         end
      end
   end

   // Offers a_items/b_items back to back for ncyc cycles; hist[k] holds the
   // state seen in cycle k, i.e. the result of edge k-1.
   task automatic run_stream(input int ncyc);
      int   ai = 0;
      int   bi = 0;
      logic ta, tb;
      for (int k = 0; k < ncyc; k++) begin
         bus.a_valid = (ai < a_items.size());
         bus.a_addr  = bus.a_valid ? a_items[ai].addr : 5'd0;
         bus.a_data  = bus.a_valid ? a_items[ai].data : 32'd0;
         bus.b_valid = (bi < b_items.size());
         bus.b_addr  = bus.b_valid ? b_items[bi].addr : 5'd0;
         bus.b_data  = bus.b_valid ? b_items[bi].data : 32'd0;
         @(negedge clk);
         rw_h[k]   = bus.reg_write;
         wr_h[k]   = bus.write_reg;
         wd_h[k]   = bus.write_data;
         ar_h[k]   = bus.a_ready;
         br_h[k]   = bus.b_ready;
         busy_h[k] = bus.busy;
         ta = bus.a_valid && bus.a_ready;
         tb = bus.b_valid && bus.b_ready;
         @(posedge clk);
         #1;
         if (ta) ai++;
         if (tb) bi++;
      end
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      check("a_all_sent", ai, a_items.size());
      check("b_all_sent", bi, b_items.size());
   endtask

   initial begin
      reset       = 1'b1;
      bus.a_valid = 1'b0;
      bus.a_addr  = '0;
      bus.a_data  = '0;
      bus.b_valid = 1'b0;
      bus.b_addr  = '0;
      bus.b_data  = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_reg_write", 32'(bus.reg_write), 32'd0);
      check("rst_write_reg", 32'(bus.write_reg), 32'd0);
      check("rst_write_data", bus.write_data, 32'd0);
      check("rst_a_ready", 32'(bus.a_ready), 32'd1);
      check("rst_b_ready", 32'(bus.b_ready), 32'd1);
      check("rst_busy", 32'(bus.busy), 32'd0);
      reset = 1'b0;

      // Reset mid-stream: one entry queued and a second handshake pending.
      bus.a_valid = 1'b1;
      bus.a_addr  = 5'd9;
      bus.a_data  = 32'h11;
      @(posedge clk);
      #1;
      check("mid_busy_before", 32'(bus.busy), 32'd1);
      bus.a_addr = 5'd10;
      bus.a_data = 32'h22;
      reset      = 1'b1;
      @(posedge clk);
      #1;
      reset       = 1'b0;
      bus.a_valid = 1'b0;
      check("mid_reg_write", 32'(bus.reg_write), 32'd0);
      check("mid_write_reg", 32'(bus.write_reg), 32'd0);
      check("mid_write_data", bus.write_data, 32'd0);
      check("mid_a_ready", 32'(bus.a_ready), 32'd1);
      check("mid_b_ready", 32'(bus.b_ready), 32'd1);
      check("mid_busy", 32'(bus.busy), 32'd0);
      repeat (3) begin
         @(posedge clk);
         #1;
         check("mid_no_write", 32'(bus.reg_write), 32'd0);
         check("mid_idle", 32'(bus.busy), 32'd0);
      end

      // Single write, two-edge latency.
      a_items = '{mk(5'd5, 32'hDEADBEEF)};
      b_items = '{};
      exp_q.push_back(mk(5'd5, 32'hDEADBEEF));
      run_stream(5);
      check("single_not_early", 32'(rw_h[1]), 32'd0);
      check("single_rw", 32'(rw_h[2]), 32'd1);
      check("single_reg", 32'(wr_h[2]), 32'd5);
      check("single_data", wd_h[2], 32'hDEADBEEF);
      check("single_rw_off", 32'(rw_h[3]), 32'd0);
      check("single_busy_off", 32'(busy_h[3]), 32'd0);

      // Backpressure on B plus starvation: issue order A,A,A,B repeating.
      a_items = '{};
      b_items = '{};
      for (int i = 0; i < 8; i++) a_items.push_back(mk(5'd1, 32'hA0 + 32'(i)));
      for (int i = 0; i < 4; i++) b_items.push_back(mk(5'd2, 32'hB0 + 32'(i)));
      exp_q.push_back(mk(5'd1, 32'hA0));
      exp_q.push_back(mk(5'd1, 32'hA1));
      exp_q.push_back(mk(5'd1, 32'hA2));
      exp_q.push_back(mk(5'd2, 32'hB0));
      exp_q.push_back(mk(5'd1, 32'hA3));
      exp_q.push_back(mk(5'd1, 32'hA4));
      exp_q.push_back(mk(5'd1, 32'hA5));
      exp_q.push_back(mk(5'd2, 32'hB1));
      exp_q.push_back(mk(5'd1, 32'hA6));
      exp_q.push_back(mk(5'd1, 32'hA7));
      exp_q.push_back(mk(5'd2, 32'hB2));
      exp_q.push_back(mk(5'd2, 32'hB3));
      run_stream(16);
      check("bp_b_ready_one", 32'(br_h[1]), 32'd1);
      check("bp_b_ready_full", 32'(br_h[2]), 32'd0);
      check("bp_b_ready_pop_edge", 32'(br_h[4]), 32'd0);
      check("bp_b_ready_after_pop", 32'(br_h[5]), 32'd1);
      check("bp_a_ready_full", 32'(ar_h[5]), 32'd0);
      check("starve_first_b", wd_h[5], 32'hB0);
      check("starve_idle", 32'(busy_h[14]), 32'd0);

      // Register 0 write takes a slot but is not issued.
      a_items = '{};
      b_items = '{mk(5'd0, 32'h1), mk(5'd7, 32'h2)};
      exp_q.push_back(mk(5'd7, 32'h2));
      run_stream(6);
      check("dz_slot_rw", 32'(rw_h[2]), 32'd0);
      check("dz_slot_reg", 32'(wr_h[2]), 32'd0);
      check("dz_slot_data", wd_h[2], 32'h1);
      check("dz_next_rw", 32'(rw_h[3]), 32'd1);
      check("dz_next_reg", 32'(wr_h[3]), 32'd7);
      check("dz_next_data", wd_h[3], 32'h2);
      check("dz_after", 32'(rw_h[4]), 32'd0);

      // Ten back-to-back entries through A: order, pointer wrap, busy drop.
      a_items = '{};
      b_items = '{};
      for (int i = 1; i <= 10; i++) begin
         a_items.push_back(mk(5'd3, 32'(i)));
         exp_q.push_back(mk(5'd3, 32'(i)));
      end
      run_stream(14);
      for (int k = 0; k <= 10; k++) check("wrap_a_ready", 32'(ar_h[k]), 32'd1);
      check("wrap_last_rw", 32'(rw_h[11]), 32'd1);
      check("wrap_last_data", wd_h[11], 32'd10);
      check("wrap_busy_last", 32'(busy_h[11]), 32'd1);
      check("wrap_busy_drop", 32'(busy_h[12]), 32'd0);
      check("wrap_rw_drop", 32'(rw_h[12]), 32'd0);

      repeat (2) @(posedge clk);
      check("sb_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writeback sources.
- Source A is the load/memory return path. Source B is the ALU result path.
- Each source has a small in-order FIFO behind a valid/ready handshake. A fixed-priority arbiter with starvation protection drains the FIFOs into a registered write port that drives the register file's reg_write/write_reg/write_data inputs.

Parameters:
- DATA_W, 32, writeback data width.
- ADDR_W, 5, register index width.
- FIFO_DEPTH, 2, entries per source FIFO; power of two, ≥2.
- STARVE_LIMIT, 3, consecutive lost arbitrations after which B is forced to win; range 1..15.
- DROP_ZERO, 1, when 1 a write to register 0 is accepted but never issued.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk only.
- a_valid  in  1  source A offers a write.
- a_ready  out  1  source A FIFO can accept.
- a_addr  in  ADDR_W  source A destination register.
- a_data  in  DATA_W  source A write data.
- b_valid  in  1  source B offers a write.
- b_ready  out  1  source B FIFO can accept.
- b_addr  in  ADDR_W  source B destination register.
- b_data  in  DATA_W  source B write data.
- reg_write  out  1  write enable to register file.
- write_reg  out  ADDR_W  register index to register file.
- write_data  out  DATA_W  data to register file.
- busy  out  1  any FIFO non-empty or reg_write high.

Behaviour:
- Reset (synchronous, priority over all else):
  - Both FIFOs are emptied and the starvation counter goes to 0.
  - Outputs after the reset edge: reg_write=0, write_reg=0, write_data=0, a_ready=1, b_ready=1, busy=0.
  - Entries in flight are discarded. Asserting reset mid-stream loses them silently.
- Handshake:
  - A transfer occurs on a clock edge where x_valid && x_ready.
  - x_ready = !full(x), computed from the occupancy before that edge. No same-cycle pass-through when full, even if a pop occurs in the same cycle.
  - x_addr/x_data are sampled only on a transfer.
  - Push and pop on the same FIFO in the same edge keep the occupancy unchanged.
- Arbitration, evaluated combinationally each cycle on FIFO heads:
  - Only A non-empty: grant A.
  - Only B non-empty: grant B.
  - Both non-empty: grant A unless starve_cnt ≥ STARVE_LIMIT, then grant B.
  - Neither non-empty: no grant.
- Starvation counter, 4 bits, saturating at 15:
  - Increments on an edge where B is non-empty and A is granted.
  - Clears on an edge where B is granted or B is empty.
- Issue:
  - The granted head is popped on the edge.
  - On that same edge the output registers load reg_write=1 (0 if DROP_ZERO && addr==0), write_reg=addr, write_data=data.
  - With no grant, reg_write loads 0; write_reg and write_data hold their previous values.
- Latency:
  - Handshake at edge N → reg_write high during the cycle after edge N+1 → register file updated at edge N+2.
  - Sustained throughput is one write per cycle in total across both sources.
- Ordering:
  - FIFO order is kept within a source.
  - No ordering between sources, including for the same address. The issuing pipeline owns that hazard.
- Register 0 writes with DROP_ZERO=1 still consume one issue slot, and the pop is counted for the starvation logic.
- Width rules: no arithmetic on data. FIFO pointers are log2(FIFO_DEPTH) bits with natural wrap-around. Occupancy is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package regfile_pkg:
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32.
  - Grant encoding: GNT_NONE=2'b00, GNT_A=2'b01, GNT_B=2'b10.
- One natural sub-module, wb_fifo: a parameterised synchronous FIFO (push, pop, full, empty, head data/addr, same reset). It is instantiated once per source.
- The arbiter, starvation counter and output registers stay in regfile_wb_arbiter.

Test Plan:
1. Reset mid-stream: fill A with 2 entries, assert reset for one edge → a_ready=1, busy=0, reg_write=0 next cycle; no write reaches the register file.
2. Single write: a_valid with addr=5, data=0xDEADBEEF at edge N → reg_write=1, write_reg=5, write_data=0xDEADBEEF during cycle after N+1; deasserted afterwards.
3. Backpressure: hold b_valid with no pop possible (A continuously fed) → b_ready=0 after 2 transfers. A same-edge pop keeps b_ready low for that edge.
4. Starvation: A and B kept permanently non-empty, STARVE_LIMIT=3 → issue sequence A,A,A,B,A,A,A,B… with B data in order.
5. DROP_ZERO: B writes addr=0, data=0x1 then addr=7, data=0x2 → one slot with reg_write=0, then reg_write=1, write_reg=7, write_data=0x2.
6. Order and wrap: push 10 entries to A (data 1..10) at full rate → issued in order 1..10, pointers wrap without loss, busy drops 1 cycle after the last issue.
